// File: rtl/cla4bitbist.sv
// Built-in self-test sweep for a WIDTH-bit adder: drives every {Cin, A, B} vector,
// checks {cout, sum} against a full-width reference and records the outcome.
module cla4bitbist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic                 Cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_seen,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int unsigned VW          = 2 * WIDTH + 1;
    localparam int unsigned EW          = 2 * WIDTH + 2;
    localparam int unsigned CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam state_t RUN_STATE = (SETTLE == 0) ? ST_CHECK : ST_WAIT;

    state_t          state;
    state_t          state_next;
    logic [VW-1:0]   vec;
    logic [CW-1:0]   cnt;
    logic            load_first_c;
    logic            last_vec_c;
    logic            mismatch_c;
    logic [WIDTH:0]  expected_c;

    assign B   = vec[WIDTH-1:0];
    assign A   = vec[2*WIDTH-1:WIDTH];
    assign Cin = vec[2*WIDTH];

    // Reference is one bit wider than the operands so the carry is checked explicitly.
    assign expected_c = (WIDTH+1)'(A) + (WIDTH+1)'(B) + (WIDTH+1)'(Cin);
    assign mismatch_c = ({cout, sum} != expected_c);
    assign last_vec_c = (vec == {VW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_first_c = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next   = RUN_STATE;
                    load_first_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == CW'(SETTLE_LAST)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = last_vec_c ? ST_DONE : RUN_STATE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Vector, settle counter and result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_next == ST_WAIT) || (state_next == ST_CHECK);
            done <= (state_next == ST_DONE);
            if (load_first_c) begin
                vec        <= '0;
                cnt        <= '0;
                err_count  <= '0;
                fail_seen  <= 1'b0;
                first_fail <= '0;
                pass       <= 1'b0;
            end else if (state == ST_WAIT) begin
                cnt <= (cnt == CW'(SETTLE_LAST)) ? '0 : cnt + CW'(1);
            end else if (state == ST_CHECK) begin
                if (mismatch_c) begin
                    if (err_count != {EW{1'b1}}) begin
                        err_count <= err_count + EW'(1);
                    end
                    if (!fail_seen) begin
                        first_fail <= vec;
                        fail_seen  <= 1'b1;
                    end
                end
                if (last_vec_c) begin
                    pass <= !mismatch_c && (err_count == '0);
                end else begin
                    vec <= vec + VW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla4bitbist.sv
// Directed bench for cla4bitbist: behavioural adder with injectable faults,
// one SETTLE=1 instance and one SETTLE=0 instance.
module tb_cla4bitbist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start0;
    int         fault;
    int         tests;
    int         failed;

    logic [3:0] a1, b1, s1;
    logic       c1, co1, busy1, done1, pass1, fs1;
    logic [9:0] err1;
    logic [8:0] ff1;

    logic [3:0] a0, b0, s0;
    logic       c0, co0, busy0, done0, pass0, fs0;
    logic [9:0] err0;
    logic [8:0] ff0;

    logic [4:0] full1;
    logic [4:0] full0;

    always #5 clk = ~clk;

    // Adder models; the SETTLE=1 one can have cout or sum[0] stuck at zero.
    always_comb begin
        full1 = 5'(a1) + 5'(b1) + 5'(c1);
        s1    = full1[3:0];
        co1   = full1[4];
        if (fault == 1) co1 = 1'b0;
        if (fault == 2) s1[0] = 1'b0;
    end

    always_comb begin
        full0 = 5'(a0) + 5'(b0) + 5'(c0);
        s0    = full0[3:0];
        co0   = full0[4];
    end

    cla4bitbist #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(a1), .B(b1), .Cin(c1), .sum(s1), .cout(co1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_seen(fs1), .first_fail(ff1)
    );

    cla4bitbist #(.WIDTH(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .A(a0), .B(b0), .Cin(c0), .sum(s0), .cout(co0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_seen(fs0), .first_fail(ff0)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; start0 = 1'b0; fault = 0;
        do_reset();
        tests++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fs1, ff1} !== 33'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {a1, b1, c1, busy1, done1, pass1, err1, fs1, ff1});
            failed++;
        end
        tests++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fs0, ff0} !== 33'd0) begin
            $display("FAIL reset_outputs0: got %h expected 0",
                     {a0, b0, c0, busy0, done0, pass0, err0, fs0, ff0});
            failed++;
        end
    endtask

    // Full SETTLE=1 sweep: start sampled at edge k, done after edge k+1024.
    task automatic run_sweep(input string name);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({busy1, done1, c1, a1, b1} !== {2'b10, 9'h000}) begin
            $display("FAIL %s_start: busy/done/vec got %b/%b/%h expected 1/0/000",
                     name, busy1, done1, {c1, a1, b1});
            failed++;
        end
        step(1023);
        tests++;
        if ({busy1, done1} !== 2'b10) begin
            $display("FAIL %s_k1023: busy/done got %b/%b expected 1/0", name, busy1, done1);
            failed++;
        end
        step(1);
        tests++;
        if ({busy1, done1, c1, a1, b1} !== {2'b01, 9'h1FF}) begin
            $display("FAIL %s_k1024: busy/done/vec got %b/%b/%h expected 0/1/1ff",
                     name, busy1, done1, {c1, a1, b1});
            failed++;
        end
    endtask

    task automatic test_sweep_pass();
        fault = 0;
        run_sweep("pass");
        tests++;
        if ({pass1, err1, fs1} !== {1'b1, 10'd0, 1'b0}) begin
            $display("FAIL pass_result: pass/err/fail_seen got %b/%0d/%b expected 1/0/0",
                     pass1, err1, fs1);
            failed++;
        end
    endtask

    task automatic test_fault_cout();
        fault = 1;
        run_sweep("cout0");
        tests++;
        if ({pass1, err1, fs1, ff1} !== {1'b0, 10'd256, 1'b1, 9'h01F}) begin
            $display("FAIL cout0_result: pass/err/fs/first got %b/%0d/%b/%h expected 0/256/1/01f",
                     pass1, err1, fs1, ff1);
            failed++;
        end
        fault = 0;
    endtask

    task automatic test_fault_sum0();
        fault = 2;
        run_sweep("sum0");
        tests++;
        if ({pass1, err1, fs1, ff1} !== {1'b0, 10'd256, 1'b1, 9'h001}) begin
            $display("FAIL sum0_result: pass/err/fs/first got %b/%0d/%b/%h expected 0/256/1/001",
                     pass1, err1, fs1, ff1);
            failed++;
        end
        fault = 0;
    endtask

    task automatic test_reset_mid();
        fault = 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(299);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fs1, ff1} !== 33'd0) begin
            $display("FAIL midrst_outputs: got %h expected 0",
                     {a1, b1, c1, busy1, done1, pass1, err1, fs1, ff1});
            failed++;
        end
        step(3);
        tests++;
        if ({busy1, done1, c1, a1, b1} !== 11'd0) begin
            $display("FAIL midrst_idle: busy/done/vec got %b/%b/%h expected 0/0/000",
                     busy1, done1, {c1, a1, b1});
            failed++;
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({busy1, c1, a1, b1} !== {1'b1, 9'h000}) begin
            $display("FAIL midrst_restart: busy/vec got %b/%h expected 1/000", busy1, {c1, a1, b1});
            failed++;
        end
        step(2);
        tests++;
        if ({c1, a1, b1} !== 9'h001) begin
            $display("FAIL midrst_vec1: vec got %h expected 001", {c1, a1, b1});
            failed++;
        end
        fault = 0;
        do_reset();
    endtask

    task automatic test_start_while_busy();
        fault = 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(499);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({busy1, done1} !== 2'b10) begin
            $display("FAIL busy_start_k500: busy/done got %b/%b expected 1/0", busy1, done1);
            failed++;
        end
        step(523);
        tests++;
        if (done1 !== 1'b0) begin
            $display("FAIL busy_start_k1023: done got %b expected 0", done1);
            failed++;
        end
        step(1);
        tests++;
        if ({done1, err1} !== {1'b1, 10'd256}) begin
            $display("FAIL busy_start_k1024: done/err got %b/%0d expected 1/256", done1, err1);
            failed++;
        end
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({busy1, done1, err1, fs1, pass1} !== {2'b10, 10'd0, 2'b00}) begin
            $display("FAIL restart_clear: busy/done/err/fs/pass got %b/%b/%0d/%b/%b expected 1/0/0/0/0",
                     busy1, done1, err1, fs1, pass1);
            failed++;
        end
        fault = 0;
        do_reset();
    endtask

    task automatic test_settle0();
        int bad;
        bad = 0;
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        for (int n = 0; n < 512; n++) begin
            tests++;
            if ({c0, a0, b0} !== 9'(n)) begin
                if (bad < 8) begin
                    $display("FAIL s0_vec: cycle %0d vec got %h expected %h", n, {c0, a0, b0}, 9'(n));
                end
                bad++;
                failed++;
            end
            if (n < 511) step(1);
        end
        tests++;
        if ({busy0, done0} !== 2'b10) begin
            $display("FAIL s0_k511: busy/done got %b/%b expected 1/0", busy0, done0);
            failed++;
        end
        step(1);
        tests++;
        if ({busy0, done0, pass0, err0, fs0} !== {3'b011, 10'd0, 1'b0}) begin
            $display("FAIL s0_k512: busy/done/pass/err/fs got %b/%b/%b/%0d/%b expected 0/1/1/0/0",
                     busy0, done0, pass0, err0, fs0);
            failed++;
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        fault  = 0;
        step(1);
        test_reset();
        test_sweep_pass();
        test_fault_cout();
        test_fault_sum0();
        test_reset_mid();
        test_start_while_busy();
        test_settle0();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cla4bitbist.md
# cla4bitbist

Self-checking stimulus and response block for the 4-bit carry-lookahead adder (`cla4bitbl`). On `start` it drives every {Cin, A, B} combination into the adder and compares the adder's `{cout, sum}` against an internal `A+B+Cin` reference. It accumulates a mismatch count, captures the first failing vector, and reports pass/fail. The block sits beside the adder as a synthesizable replacement for a bench-driven sweep, usable on silicon or FPGA.

## Interface
Parameters:
- `WIDTH`, 4: adder operand width. Vector space is 2^(2·WIDTH+1).
- `SETTLE`, 1: number of cycles (≥0) between driving a vector and sampling the response.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a sweep. Sampled only in IDLE or DONE.
- `A` out WIDTH: operand A to the adder. Registered.
- `B` out WIDTH: operand B to the adder. Registered.
- `Cin` out 1: carry-in to the adder. Registered.
- `sum` in WIDTH: adder sum response.
- `cout` in 1: adder carry-out response.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete. Held until the next `start` or `rst`.
- `pass` out 1: `done` && `err_count`==0.
- `err_count` out 2·WIDTH+2: number of mismatching vectors. Saturates at all-ones.
- `fail_seen` out 1: at least one mismatch recorded.
- `first_fail` out 2·WIDTH+1: index of the first mismatching vector.

## Operation
- Vector index v is 2·WIDTH+1 bits wide, encoded as B=v[WIDTH-1:0], A=v[2W-1:W], Cin=v[2W]. The sweep runs v=0 upward to all-ones with no skips or repeats.
- States:
  - IDLE: `busy`=0, `done`=0.
  - WAIT: holds the current vector for SETTLE cycles. Skipped when SETTLE=0.
  - CHECK: one cycle.
  - DONE.
- IDLE/DONE with `start`=1 → WAIT (or CHECK if SETTLE=0):
  - load v=0 onto A/B/Cin
  - clear `err_count`, `fail_seen`, `first_fail`
  - set `busy`=1, `done`=0
- WAIT → CHECK once the settle counter reaches SETTLE.
- CHECK:
  - Compare `{cout,sum}` against the WIDTH+1-bit result of A+B+Cin computed from the registered outputs.
  - On mismatch: `err_count`++ (saturating). If `fail_seen`=0, capture `first_fail`=v and set `fail_seen`=1.
  - If v is not last: load v+1 and go to WAIT/CHECK.
  - If v is last: go to DONE with `busy`=0, `done`=1. A/B/Cin hold the last vector.
- `start` while `busy`=1 is ignored.
- The reference sum is full width (WIDTH+1 bits), so there is no wrap and the carry is compared explicitly.

## Timing
- Reset values: A=0, B=0, Cin=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_seen`=0, `first_fail`=0. State is IDLE.
- `rst` has priority over everything. Asserted mid-sweep, it aborts the sweep and all outputs take their reset values after that edge. No partial results are retained.
- With `start` sampled at edge k:
  - vector 0 is visible after edge k
  - vector n is compared at edge k+(n+1)(SETTLE+1)
  - `busy`→0 and `done`→1 after edge k+2^(2W+1)·(SETTLE+1)
  - for defaults this is edge k+1024
- `pass` and `err_count` are final in the same cycle that `done` rises.
- `start` in DONE restarts at the next edge, with `done` dropping on that edge.
- The adder response must be valid within SETTLE+1 cycles of the vector update. The block applies no further wait.

## Test plan
- Correct `cla4bitbl` connected, SETTLE=1, `start` pulsed at edge k:
  - `busy` high from k+1
  - `done`=1 and `pass`=1 after edge k+1024
  - `err_count`=0, `fail_seen`=0
- Adder `cout` forced to 0:
  - `err_count`=256 (120 vectors with Cin=0, 136 with Cin=1)
  - `first_fail`=9'h01F (A=1, B=15, Cin=0)
  - `pass`=0
- Adder `sum[0]` forced to 0:
  - `err_count`=256
  - `first_fail`=9'h001
  - `pass`=0
- `rst` asserted at edge k+300 mid-sweep:
  - all outputs equal reset values after that edge
  - a new `start` sweeps from v=0, with A/B/Cin=0/0/0 after the start edge
- `start` re-pulsed at edge k+500 while busy: ignored, and `done` still rises exactly at edge k+1024. A later `start` in DONE clears `done`, `err_count` and `fail_seen` on the next edge.
- SETTLE=0 with a correct adder: `done` after edge k+512 with `pass`=1. Checking A/B/Cin on every cycle shows each of the 512 vectors exactly once, in ascending order.
